// File: rtl/tt_scan_pkg.sv
// Shared definitions for the truth-table scanner.
//   N_IN    : number of inputs of the function block under scan
//   TT_W    : truth-table width (2**N_IN)
//   *_ENC   : state encodings used by the scanner FSM
//   state_t : FSM state type built on those encodings
package tt_scan_pkg;

    localparam int unsigned N_IN = 3;
    localparam int unsigned TT_W = 8;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] DRIVE_ENC  = 2'd1;
    localparam logic [1:0] SAMPLE_ENC = 2'd2;
    localparam logic [1:0] DONE_ENC   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = IDLE_ENC,
        DRIVE  = DRIVE_ENC,
        SAMPLE = SAMPLE_ENC,
        DONE   = DONE_ENC
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Dwell timer for the DRIVE state of the truth-table scanner.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : returns the count to 0 (held while not dwelling)
//   enable  : advances the count by one per cycle
//   expired : high in the last cycle of the dwell (count == SETTLE_CYCLES-1)
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Stimulus-and-capture harness around a 3-input combinational function.
// Walks {x,y,z} through 0..7, samples f_in after SETTLE_CYCLES of dwell
// per index, builds an 8-bit truth table and compares it against EXPECTED.
//   clk, reset   : clock and synchronous active-high reset
//   start        : scan request, accepted only in IDLE
//   f_in         : output of the function block under scan
//   x, y, z      : function inputs, {x,y,z} = current index
//   busy         : high while driving/sampling
//   done         : one-cycle pulse when the scan completes
//   table_out    : captured truth table, bit i = F at index i
//   match        : table_out == EXPECTED
//   mismatch_cnt : number of differing bits (0..8)
//   first_bad    : lowest differing index, 0 when none
//
// state  | meaning
// IDLE   | waiting for start; results and last index held
// DRIVE  | {x,y,z} applied, dwelling SETTLE_CYCLES cycles
// SAMPLE | f_in captured into table_out[index] on exit
// DONE   | one-cycle done pulse, compare results valid
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned   SETTLE_CYCLES = 1,
    parameter logic [TT_W-1:0] EXPECTED    = 8'hAA
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            f_in,
    output logic            x,
    output logic            y,
    output logic            z,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_out,
    output logic            match,
    output logic [3:0]      mismatch_cnt,
    output logic [2:0]      first_bad
);

    state_t          state;
    logic [N_IN-1:0] index;
    logic            dwell_end;

    logic [TT_W-1:0] next_table;
    logic [TT_W-1:0] diff;
    logic [3:0]      diff_cnt;
    logic [2:0]      diff_first;
    logic            diff_found;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != DRIVE),
        .enable (state == DRIVE),
        .expired(dwell_end)
    );

    // The compare registers load on the SAMPLE->DONE edge, so they must see
    // the table including the bit being captured on that same edge.
    always_comb begin
        next_table        = table_out;
        next_table[index] = f_in;
    end

    assign diff = next_table ^ EXPECTED;

    always_comb begin
        diff_cnt = '0;
        for (int i = 0; i < int'(TT_W); i++) begin
            diff_cnt = diff_cnt + {3'b000, diff[i]};
        end
    end

    always_comb begin
        diff_first = '0;
        diff_found = 1'b0;
        for (int i = 0; i < int'(TT_W); i++) begin
            if (diff[i] && !diff_found) begin
                diff_first = 3'(i);
                diff_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            x            <= 1'b0;
            y            <= 1'b0;
            z            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= DRIVE;
                        index        <= '0;
                        {x, y, z}    <= 3'b000;
                        busy         <= 1'b1;
                        table_out    <= '0;
                        match        <= 1'b0;
                        mismatch_cnt <= '0;
                        first_bad    <= '0;
                    end
                end
                DRIVE: begin
                    if (dwell_end) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_out <= next_table;
                    if (index == 3'd7) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        match        <= (diff == '0);
                        mismatch_cnt <= diff_cnt;
                        first_bad    <= diff_first;
                    end else begin
                        state     <= DRIVE;
                        index     <= index + 3'd1;
                        {x, y, z} <= index + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters; instance B: SETTLE_CYCLES=3
    logic       rst_a, start_a, f_a, x_a, y_a, z_a, busy_a, done_a, match_a;
    logic [7:0] tbl_a;
    logic [3:0] cnt_a;
    logic [2:0] fb_a;
    logic       rst_b, start_b, f_b, x_b, y_b, z_b, busy_b, done_b, match_b;
    logic [7:0] tbl_b;
    logic [3:0] cnt_b;
    logic [2:0] fb_b;

    int mode_a = 0;
    int mode_b = 0;

    truth_table_scanner dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .f_in(f_a),
        .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
        .table_out(tbl_a), .match(match_a), .mismatch_cnt(cnt_a), .first_bad(fb_a)
    );

    truth_table_scanner #(.SETTLE_CYCLES(3), .EXPECTED(8'hAA)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .f_in(f_b),
        .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
        .table_out(tbl_b), .match(match_b), .mismatch_cnt(cnt_b), .first_bad(fb_b)
    );

    function automatic logic model(input int mode, input logic fx, input logic fy, input logic fz);
        case (mode)
            0:       return fz;
            1:       return 1'b0;
            2:       return ~fz;
            3:       return fy;
            4:       return fx;
            5:       return 1'b1;
            default: return fx ^ fy ^ fz;
        endcase
    endfunction

    always_comb f_a = model(mode_a, x_a, y_a, z_a);
    always_comb f_b = model(mode_b, x_b, y_b, z_b);

    // selected-instance views used by the generic scan task
    int         sel = 0;
    logic       busy_s, done_s, match_s;
    logic [2:0] xyz_s;
    logic [7:0] tbl_s;
    logic [3:0] cnt_s;
    logic [2:0] fb_s;
    always_comb begin
        busy_s = busy_a; done_s = done_a; match_s = match_a;
        xyz_s = {x_a, y_a, z_a}; tbl_s = tbl_a; cnt_s = cnt_a; fb_s = fb_a;
        if (sel == 1) begin
            busy_s = busy_b; done_s = done_b; match_s = match_b;
            xyz_s = {x_b, y_b, z_b}; tbl_s = tbl_b; cnt_s = cnt_b; fb_s = fb_b;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start_b = v; else start_a = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input int s, input int mode, input logic [7:0] et, input logic em,
                            input logic [3:0] ec, input logic [2:0] efb, input int settle,
                            input bit poke);
        int busy_cnt;
        int xyz_bad;
        int extra_done;
        int extra_busy;
        sel = s;
        if (s == 1) mode_b = mode; else mode_a = mode;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        busy_cnt = 0;
        xyz_bad  = 0;
        while (busy_s && busy_cnt < 300) begin
            if (int'(xyz_s) != busy_cnt / (settle + 1)) xyz_bad++;
            set_start(s, poke && (busy_cnt == 5));
            busy_cnt++;
            tick();
        end
        set_start(s, 1'b0);
        chk("busy_len", busy_cnt, 8 * (settle + 1));
        chk("xyz_sequence", xyz_bad, 0);
        chk("done_pulse", done_s, 1'b1);
        chk("table_out", tbl_s, et);
        chk("match", match_s, em);
        chk("mismatch_cnt", cnt_s, ec);
        chk("first_bad", fb_s, efb);
        if (poke) set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        chk("done_width", done_s, 1'b0);
        chk("xyz_hold_111", xyz_s, 3'b111);
        // results must hold in IDLE even if the function output changes
        if (s == 1) mode_b = 6; else mode_a = 6;
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_s) extra_done++;
            if (busy_s) extra_busy++;
            tick();
        end
        chk("no_extra_done", extra_done, 0);
        chk("no_extra_busy", extra_busy, 0);
        chk("table_hold", tbl_s, et);
        chk("cnt_hold", cnt_s, ec);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] tbl;
        logic       m;
        logic [3:0] cnt;
        logic [2:0] fb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        int seen_busy;
        int waited;

        vecs[0] = '{mode: 0, tbl: 8'hAA, m: 1'b1, cnt: 4'd0, fb: 3'd0}; // F = z
        vecs[1] = '{mode: 1, tbl: 8'h00, m: 1'b0, cnt: 4'd4, fb: 3'd1}; // F = 0
        vecs[2] = '{mode: 2, tbl: 8'h55, m: 1'b0, cnt: 4'd8, fb: 3'd0}; // F = ~z
        vecs[3] = '{mode: 4, tbl: 8'hF0, m: 1'b0, cnt: 4'd4, fb: 3'd1}; // F = x
        vecs[4] = '{mode: 5, tbl: 8'hFF, m: 1'b0, cnt: 4'd4, fb: 3'd0}; // F = 1
        vecs[5] = '{mode: 6, tbl: 8'h96, m: 1'b0, cnt: 4'd4, fb: 3'd2}; // F = parity

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        chk("reset_a_outputs", {x_a, y_a, z_a, busy_a, done_a, tbl_a, match_a, cnt_a, fb_a}, 0);
        chk("reset_b_outputs", {x_b, y_b, z_b, busy_b, done_b, tbl_b, match_b, cnt_b, fb_b}, 0);

        for (int i = 0; i < 6; i++) begin
            run_scan(0, vecs[i].mode, vecs[i].tbl, vecs[i].m, vecs[i].cnt, vecs[i].fb, 1, 1'b0);
        end

        // longer dwell, F = y
        run_scan(1, 3, 8'hCC, 1'b0, 4'd4, 3'd1, 3, 1'b0);

        // start re-pulsed while busy and during done
        run_scan(0, 0, 8'hAA, 1'b1, 4'd0, 3'd0, 1, 1'b1);
        run_scan(1, 2, 8'h55, 1'b0, 4'd8, 3'd0, 3, 1'b1);

        // reset in the middle of a scan, at index 4
        sel = 0;
        mode_a = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        waited = 0;
        while ({x_a, y_a, z_a} != 3'd4 && waited < 100) begin
            waited++;
            tick();
        end
        chk("reach_index4", {x_a, y_a, z_a}, 3'd4);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("midscan_reset_outputs", {x_a, y_a, z_a, busy_a, done_a, tbl_a, match_a, cnt_a, fb_a}, 0);
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (done_a) seen_done++;
            if (busy_a) seen_busy++;
            tick();
        end
        chk("midscan_no_done", seen_done, 0);
        chk("midscan_stays_idle", seen_busy, 0);
        run_scan(0, 0, 8'hAA, 1'b1, 4'd0, 3'd0, 1, 1'b0);

        // reset and start together: reset wins
        rst_a = 1'b1;
        start_a = 1'b1;
        tick();
        rst_a = 1'b0;
        start_a = 1'b0;
        chk("reset_beats_start_busy", busy_a, 1'b0);
        chk("reset_beats_start_table", tbl_a, 8'h00);
        tick();
        chk("reset_beats_start_idle", busy_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequential stimulus-and-capture stage wrapped around a 3-input combinational function block such as the decoder-based minterm function. It drives x, y, z upstream of the function through all 8 input combinations in ascending order and consumes the function's output F downstream. It records F into an 8-bit truth-table register and compares that register against an expected minterm mask. The result is a self-checking harness that synthesises alongside the decoder-based function blocks.

Parameters:
SETTLE_CYCLES, 1, clock cycles each input combination is held before F is sampled; legal range 1..15.
EXPECTED, 8'hAA, expected truth table, bit i = F for {x,y,z}=i; default is Sum(1,3,5,7).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a scan; honoured only in IDLE
f_in  input  1  output F of the function block under scan
x  output  1  function input, MSB of the index
y  output  1  function input, middle bit
z  output  1  function input, LSB of the index
busy  output  1  high while in DRIVE or SAMPLE
done  output  1  one-cycle pulse when the scan completes
table_out  output  8  captured truth table, bit i = f_in sampled for index i
match  output  1  table_out == EXPECTED, valid from the done pulse onward
mismatch_cnt  output  4  popcount(table_out ^ EXPECTED), range 0..8
first_bad  output  3  lowest index where table_out differs from EXPECTED; 0 if none

Behaviour:
- Reset state: all outputs 0 (x=y=z=0, busy=0, done=0, table_out=0, match=0, mismatch_cnt=0, first_bad=0); FSM in IDLE; index counter 0; settle counter 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE, with index=0, table_out cleared to 0, and match/mismatch_cnt/first_bad cleared to 0.
- DRIVE: {x,y,z} = index, registered. Stays for exactly SETTLE_CYCLES cycles (settle counter counts 0..SETTLE_CYCLES-1), then -> SAMPLE.
- SAMPLE: one cycle. On the edge leaving SAMPLE, table_out[index] <= f_in.
  - If index==7 -> DONE.
  - Otherwise index <= index+1 and -> DRIVE.
- DONE: one cycle, with done=1 and busy=0.
  - match, mismatch_cnt and first_bad are registered from the complete table, so they are valid in the same cycle done=1.
  - Next state is always IDLE.
- Latency: busy rises the cycle after start is sampled and stays high for exactly 8*(SETTLE_CYCLES+1) cycles. done is high in the following cycle. With the default, busy lasts 16 cycles and done occurs 17 cycles after the start edge.
- x, y, z change only on DRIVE entry and hold through SAMPLE. They hold their last value (111) in DONE/IDLE until the next start, then return to 000.
- start is ignored in DRIVE, SAMPLE and DONE; no queuing.
- table_out and the compare outputs hold their values in IDLE until the next accepted start.
- Reset asserted mid-scan: on the next edge everything returns to the reset state; the partial table is discarded; no done pulse.
- Simultaneous reset and start: reset wins.
- Width rules:
  - Index is 3 bits; wrap from 7 is impossible because DONE is taken instead.
  - mismatch_cnt is 4 bits so the value 8 is representable.
  - first_bad is computed by a priority scan from bit 0.

Decomposition:
- Shared package tt_scan_pkg:
  - State encoding localparams: IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - N_IN=3 and TT_W=8.
- One sub-module, settle_timer: load/count/expire for the DRIVE dwell, parameterised by SETTLE_CYCLES.
- The popcount and priority scan stay inline as combinational logic feeding the DONE registers.

Test Plan:
1. f_in driven by a model of Sum(1,3,5,7) (F=z), default parameters, pulse start -> busy high 16 cycles, done one cycle later, table_out=8'hAA, match=1, mismatch_cnt=0, first_bad=0.
2. f_in tied 0 -> table_out=8'h00, match=0, mismatch_cnt=4, first_bad=1.
3. f_in = ~z -> table_out=8'h55, match=0, mismatch_cnt=8, first_bad=0.
4. SETTLE_CYCLES=3, f_in=y -> busy high exactly 32 cycles; x,y,z each stable 4 cycles per index in order 000..111; table_out=8'hCC, mismatch_cnt=4, first_bad=1.
5. Reset pulsed while index=4 -> next cycle all outputs 0 and IDLE, no done. A fresh start then completes a normal scan with table_out=8'hAA.
6. start re-pulsed during busy and during done -> ignored: exactly one done pulse, busy not extended, table_out unchanged until the next start issued from IDLE.
